// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the register hazard scoreboard.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int CNT_W      = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  localparam cnt_t CNT_MAX  = 2'd3;
  localparam cnt_t CNT_ZERO = 2'd0;
  localparam cnt_t CNT_ONE  = 2'd1;
endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// Saturating pending-writer counter for one register, with a per-cycle
// overflow/underflow event output.
module sb_counter
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output cnt_t cnt,
  output logic err
);
  logic up;
  logic down;

  // An increment and a decrement in the same cycle cancel out.
  always_comb begin
    up   = inc & ~dec;
    down = dec & ~inc;
    err  = (up && (cnt == CNT_MAX)) || (down && (cnt == CNT_ZERO));
  end

  // Count register: saturates at CNT_MAX, holds at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CNT_ZERO;
    end else if (up && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end else if (down && (cnt != CNT_ZERO)) begin
      cnt <= cnt - CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: stalls ID while a source register has a pending writer.
// Optional build macro HAZARD_FWD_EN: only outstanding loads stall (ALU results forward).
module hazard_scoreboard
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_wb_en,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic                  issue_is_load,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  src2_used,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  ld_ready_valid,
  input  logic [REG_ADDR_W-1:0] ld_ready_dest,
  output logic                  stall,
  output logic                  sb_err
);
  localparam reg_addr_t REG_ZERO = 5'd0;

  logic                accept;
  logic                wb_hit;
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] err;

  // A stalled issue is a no-op, and x0 is never tracked.
  assign accept = issue_valid & issue_wb_en & ~stall & (issue_dest != REG_ZERO);
  assign wb_hit = wb_valid & (wb_dest != REG_ZERO);

  assign pend[0] = 1'b0;
  assign err[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic inc;
    logic dec;
    cnt_t wcnt;
    logic w_err;

    assign inc = accept & (issue_dest == REG_ADDR_W'(r));
    assign dec = wb_hit & (wb_dest == REG_ADDR_W'(r));

    sb_counter u_wcnt (
      .clk (clk),
      .rst (rst),
      .inc (inc),
      .dec (dec),
      .cnt (wcnt),
      .err (w_err)
    );

`ifdef HAZARD_FWD_EN
    logic l_inc;
    logic l_dec;
    cnt_t lcnt;
    logic l_err;
    logic unused_wcnt;

    assign l_inc = inc & issue_is_load;
    assign l_dec = ld_ready_valid & (ld_ready_dest == REG_ADDR_W'(r));

    sb_counter u_lcnt (
      .clk (clk),
      .rst (rst),
      .inc (l_inc),
      .dec (l_dec),
      .cnt (lcnt),
      .err (l_err)
    );

    // Writer counts still police the protocol but no longer cause stalls.
    assign unused_wcnt = ^wcnt;
    assign pend[r]     = (lcnt != CNT_ZERO);
    assign err[r]      = w_err | l_err;
`else
    assign pend[r] = (wcnt != CNT_ZERO);
    assign err[r]  = w_err;
`endif
  end

`ifndef HAZARD_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{issue_is_load, ld_ready_valid, ld_ready_dest};
`endif

  assign stall = pend[src1] | (src2_used & pend[src2]);

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else begin
      sb_err <= sb_err | (|err);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard (default and HAZARD_FWD_EN builds).
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_wb_en, issue_is_load;
  logic [4:0] issue_dest, src1, src2, wb_dest, ld_ready_dest;
  logic       src2_used, wb_valid, ld_ready_valid;
  logic       stall, sb_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       iv;
    logic       we;
    logic [4:0] dest;
    logic       ld;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       su;
    logic       wv;
    logic [4:0] wd;
    logic       lv;
    logic [4:0] ldd;
    logic       exp_stall;
    logic       exp_err;
  } vec_t;

  vec_t tbl[$];

  hazard_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_wb_en    (issue_wb_en),
    .issue_dest     (issue_dest),
    .issue_is_load  (issue_is_load),
    .src1           (src1),
    .src2           (src2),
    .src2_used      (src2_used),
    .wb_valid       (wb_valid),
    .wb_dest        (wb_dest),
    .ld_ready_valid (ld_ready_valid),
    .ld_ready_dest  (ld_ready_dest),
    .stall          (stall),
    .sb_err         (sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic iv, input logic we, input int dest, input logic ld,
                     input int s1, input int s2, input logic su, input logic wv, input int wd,
                     input logic lv, input int ldd, input logic es, input logic ee);
    vec_t v;
    v.rst = r; v.iv = iv; v.we = we; v.dest = 5'(dest); v.ld = ld;
    v.s1 = 5'(s1); v.s2 = 5'(s2); v.su = su; v.wv = wv; v.wd = 5'(wd);
    v.lv = lv; v.ldd = 5'(ldd); v.exp_stall = es; v.exp_err = ee;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; issue_valid = v.iv; issue_wb_en = v.we; issue_dest = v.dest;
    issue_is_load = v.ld; src1 = v.s1; src2 = v.s2; src2_used = v.su;
    wb_valid = v.wv; wb_dest = v.wd; ld_ready_valid = v.lv; ld_ready_dest = v.ldd;
  endtask

  initial begin
    vec_t idle;
    idle = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};

    // Hand-written reset sequence: two reset edges, then idle.
    @(negedge clk);
    drive(idle);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_stall", 0, stall, 1'b0);
    check("reset_err", 0, sb_err, 1'b0);

    //   rst iv we dest ld s1 s2 su wv wd lv ldd  stall err
`ifdef HAZARD_FWD_EN
    add(0, 1, 1, 4, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0); // non-load to x4
    add(0, 0, 0, 0, 0,  4, 0, 0, 0, 0, 0, 0,  0, 0); // forwarded, no stall
    add(0, 1, 1, 4, 1,  0, 0, 0, 1, 4, 0, 0,  0, 0); // load to x4, first write retires
    add(0, 0, 0, 0, 0,  4, 0, 0, 0, 0, 0, 0,  1, 0); // load-use stall
    add(0, 0, 0, 0, 0,  4, 0, 0, 0, 0, 1, 4,  1, 0); // data ready at this edge
    add(0, 0, 0, 0, 0,  4, 0, 0, 1, 4, 0, 0,  0, 0); // cleared next cycle
    add(0, 1, 1, 8, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0); // load x8
    add(0, 0, 0, 0, 0,  0, 8, 0, 0, 0, 0, 0,  0, 0); // src2 unused
    add(0, 0, 0, 0, 0,  0, 8, 1, 0, 0, 0, 0,  1, 0); // src2 used
    add(0, 1, 1, 9, 1,  0, 8, 1, 0, 0, 0, 0,  1, 0); // issue while stalled ignored
    add(0, 0, 0, 0, 0,  0, 8, 1, 0, 0, 1, 8,  1, 0);
    add(0, 0, 0, 0, 0,  9, 8, 1, 0, 0, 0, 0,  0, 0); // x9 never counted
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 2,  0, 0); // lcnt underflow
    add(0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0,  0, 1);
    add(1, 1, 1, 2, 1,  0, 0, 0, 0, 0, 0, 0,  0, 1); // reset beats load issue
    add(0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0,  0, 0);
`else
    add(0, 1, 1, 5, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0); // issue x5
    add(0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0,  1, 0); // RAW stall
    add(0, 0, 0, 0, 0,  5, 0, 0, 1, 5, 0, 0,  1, 0); // writeback at this edge
    add(0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0,  0, 0); // released next cycle
    add(0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0); // x0 not tracked
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0,  0, 0);
    add(0, 1, 1, 7, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0); // wcnt7 = 1
    add(0, 1, 1, 7, 0,  0, 0, 0, 1, 7, 0, 0,  0, 0); // same-cycle inc/dec
    add(0, 1, 1, 12, 0, 7, 0, 0, 0, 0, 0, 0,  1, 0); // stalled issue to x12 ignored
    add(0, 0, 0, 0, 0,  7, 0, 0, 1, 7, 0, 0,  1, 0);
    add(0, 0, 0, 0, 0,  7, 12, 1, 0, 0, 0, 0, 0, 0); // wcnt7 was exactly 1, x12 clean
    add(0, 1, 1, 9, 1,  0, 0, 0, 0, 0, 1, 9,  0, 0); // load flag / ld_ready ignored
    add(0, 0, 0, 0, 0,  0, 9, 0, 0, 0, 0, 0,  0, 0);
    add(0, 0, 0, 0, 0,  0, 9, 1, 0, 0, 0, 0,  1, 0);
    add(0, 0, 0, 0, 0,  0, 9, 1, 1, 9, 0, 0,  1, 0);
    add(0, 0, 0, 0, 0,  0, 9, 1, 0, 0, 0, 0,  0, 0);
    for (int k = 0; k < 4; k++)
      add(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // fourth one saturates
    add(0, 0, 0, 0, 0,  3, 0, 0, 1, 3, 0, 0,  1, 1);
    add(0, 0, 0, 0, 0,  3, 0, 0, 1, 3, 0, 0,  1, 1);
    add(0, 0, 0, 0, 0,  3, 0, 0, 1, 3, 0, 0,  1, 1);
    add(0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0, 0,  0, 1); // held at 3, not 4 or wrapped
    add(1, 1, 1, 6, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1); // reset beats issue
    add(0, 0, 0, 0, 0,  6, 0, 0, 0, 0, 0, 0,  0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 1, 10, 0, 0, 0, 0); // underflow
    add(0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0,  0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0,  0, 1); // wb to x0 harmless
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0);
`endif

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check("stall", i, stall, tbl[i].exp_stall);
      check("sb_err", i, sb_err, tbl[i].exp_err);
    end

    @(negedge clk);
    drive(idle);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, rising-edge.
REQ-002 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have issue_valid  input  1  an instruction leaves ID this cycle.
REQ-004 SHALL have issue_wb_en  input  1  the issuing instruction writes the register file.
REQ-005 SHALL have issue_dest  input  5  destination register of the issuing instruction.
REQ-006 SHALL have issue_is_load  input  1  the issuing instruction is a memory load.
REQ-007 SHALL have src1, src2  input  5 each  source registers of the instruction in ID.
REQ-008 SHALL have src2_used  input  1  src2 is a real operand.
REQ-009 SHALL have wb_valid, wb_dest  input  1/5  register-file write retiring this cycle.
REQ-010 SHALL have ld_ready_valid, ld_ready_dest  input  1/5  load data is forwardable from this cycle.
REQ-011 SHALL have stall  output  1  freeze IF/ID and inject a bubble into EXE.
REQ-012 SHALL have sb_err  output  1  sticky protocol-error flag.

Function
REQ-013 SHALL keep a 2-bit pending-writer count wcnt[r] for r=1..31; r=0 is never tracked and reads as 0.
REQ-014 SHALL accept an issue only when issue_valid & issue_wb_en & !stall & issue_dest!=0; a qualifying accept increments wcnt[issue_dest] at the clock edge.
REQ-015 SHALL decrement wcnt[wb_dest] at the edge when wb_valid & wb_dest!=0.
REQ-016 SHALL leave the count unchanged when an accept and a writeback hit the same register in the same cycle.
REQ-017 SHALL saturate at 3 on an increment from 3, and hold at 0 on a decrement from 0; either case sets sb_err.
REQ-018 SHALL drive stall combinationally from registered state only: stall = pend(src1) | (src2_used & pend(src2)).
REQ-019 SHALL treat issue_valid while stall=1 as a no-op, with no count change.
REQ-020 SHALL produce stall with zero-cycle latency; a writeback at edge N clears the stall in cycle N+1.

Reset
REQ-021 SHALL, while rst=1 at an edge, clear all wcnt, all lcnt and sb_err; stall SHALL read 0 in the following cycle.
REQ-022 SHALL give rst priority over a simultaneous issue, writeback or ld_ready event, discarding those events.

Configuration
REQ-023 SHALL, when HAZARD_FWD_EN is defined, keep a 2-bit count lcnt[r] per register, incremented on an accepted issue with issue_is_load and decremented on ld_ready_valid; pend(r) = lcnt[r]!=0.
REQ-024 SHALL, when HAZARD_FWD_EN is defined, apply to lcnt the same same-cycle and saturation rules as REQ-016 and REQ-017.
REQ-025 SHALL, without HAZARD_FWD_EN, omit lcnt, ignore ld_ready_* and issue_is_load, and use pend(r) = wcnt[r]!=0.

Structure
REQ-026 SHALL take REG_ADDR_W=5, NUM_REGS=32, CNT_W=2 and CNT_MAX=3 from the shared package cpu_pkg.
REQ-027 SHALL instantiate one sub-module, sb_counter, per tracked register, containing the saturating up/down counter and its error output.

Verification
REQ-028 SHALL be verified for: issue wb_en dest=5, next cycle src1=5 -> stall=1; wb_dest=5 at edge N -> stall=0 in cycle N+1.
REQ-029 SHALL be verified for: issue dest=0 with wb_en=1, then src1=0 -> stall stays 0 and all counts stay 0.
REQ-030 SHALL be verified for: issue dest=7 and wb_dest=7 in the same cycle with wcnt[7]=1 -> wcnt[7] stays 1 and stall persists for src=7.
REQ-031 SHALL be verified for: four issues to dest=3 with no writeback -> wcnt[3]=3 and sb_err=1; rst=1 -> counts 0 and sb_err=0.
REQ-032 SHALL be verified for: src2=9 pending with src2_used=0 -> stall=0; src2_used=1 -> stall=1.
REQ-033 SHALL be verified for, with HAZARD_FWD_EN: a non-load to dest=4 followed by src1=4 -> stall=0; a load to dest=4 -> stall=1 until ld_ready_dest=4, then 0 the next cycle.
